// File: rtl/param_adder_accum.sv
// param_adder_accum: N-bit ripple adder with a debounced accumulate mode and a sticky overflow flag
module param_adder_accum #(
    parameter int WIDTH = 4,
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic               CLK100MHZ,
    input  logic               CPU_RESETN,
    input  logic [2*WIDTH-1:0] SW,
    input  logic               BTNC,
    input  logic               BTNU,
    input  logic               BTND,
    output logic [WIDTH+1:0]   led
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic [2*WIDTH-1:0] sw_m, sw_s;
    logic [2:0]         btn_raw, btn_pulse;
    logic               mode, ovf;
    logic [WIDTH-1:0]   acc, a, op_b, sum;
    logic [WIDTH:0]     c, res;

    assign btn_raw = {BTND, BTNU, BTNC};

    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN)
        if (!CPU_RESETN) begin
            sw_m <= '0;
            sw_s <= '0;
        end else begin
            sw_m <= SW;
            sw_s <= sw_m;
        end

    for (genvar k = 0; k < 3; k++) begin : g_btn
        logic           m, s, stable, stable_d, pulse;
        logic [CW-1:0]  cnt;
        always_ff @(posedge CLK100MHZ or negedge CPU_RESETN)
            if (!CPU_RESETN) begin
                m        <= 1'b0;
                s        <= 1'b0;
                stable   <= 1'b0;
                stable_d <= 1'b0;
                pulse    <= 1'b0;
                cnt      <= '0;
            end else begin
                m        <= btn_raw[k];
                s        <= m;
                stable_d <= stable;
                pulse    <= stable & ~stable_d;
                if (s == stable)
                    cnt <= '0;
                else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                    stable <= s;
                    cnt    <= '0;
                end else
                    cnt <= cnt + 1'b1;
            end
        assign btn_pulse[k] = pulse;
    end

    // one full-adder chain shared by both modes; only the second operand is muxed
    assign a    = sw_s[WIDTH-1:0];
    assign op_b = mode ? acc : sw_s[2*WIDTH-1:WIDTH];
    assign c[0] = 1'b0;
    for (genvar i = 0; i < WIDTH; i++) begin : g_fa
        assign sum[i]   = a[i] ^ op_b[i] ^ c[i];
        assign c[i + 1] = (a[i] & op_b[i]) | (c[i] & (a[i] ^ op_b[i]));
    end

    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN)
        if (!CPU_RESETN) begin
            mode <= 1'b0;
            acc  <= '0;
            ovf  <= 1'b0;
            res  <= '0;
        end else begin
            if (!mode)
                res <= {c[WIDTH], sum};
            if (btn_pulse[1]) begin
                mode <= ~mode;
                acc  <= '0;
                ovf  <= 1'b0;
            end else if (mode && btn_pulse[2]) begin
                acc <= '0;
                ovf <= 1'b0;
            end else if (mode && btn_pulse[0]) begin
                acc <= sum;
                if (c[WIDTH])
                    ovf <= 1'b1;
            end
        end

    assign led = mode ? {1'b1, ovf, acc} : {1'b0, res};
endmodule
